// File: rtl/mc_control.sv
// ============================================================================
// mc_control -- multi-cycle MIPS main control unit
//
// Purpose:
//   Moore FSM that steps each instruction through fetch, decode, execute,
//   memory and writeback on the shared-memory, single-ALU datapath. The states
//   that touch memory (FETCH, MEMRD, MEMWR) wait on mem_ready. A counter
//   reports how many instructions have retired.
//
// Optional feature (compile-time macro MC_CONTROL_ILLEGAL_TRAP_EN):
//   defined   : an unrecognised opcode in DECODE traps to HALT, raises the
//               sticky illegal_op flag, and only reset leaves HALT.
//   undefined : an unrecognised opcode is a NOP (back to FETCH) and
//               illegal_op is tied to 0.
//
// Handshake:
//   mem_ready is sampled only in FETCH, MEMRD and MEMWR. The state's memory
//   request (MemRead / MemWrite) stays high on every cycle until the cycle in
//   which mem_ready=1, which completes the access; the FSM advances on the
//   following edge.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   opcode       in   IR[31:26], valid from DECODE onward
//   mem_ready    in   memory completes the current access this cycle
//   PCWrite      out  unconditional PC update
//   PCWriteCond  out  PC update if ALU zero
//   IorD         out  memory address source (0 PC, 1 ALUOut)
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   IRWrite      out  load instruction register
//   MemtoReg     out  register write data from MDR
//   RegDst       out  destination rd (1) or rt (0)
//   RegWrite     out  register file write
//   ALUSrcA      out  ALU A (0 PC, 1 rs)
//   ALUSrcB      out  ALU B (00 rt, 01 4, 10 imm, 11 imm<<2)
//   ALUOp        out  to ALU control (00 add, 01 sub, 10 funct)
//   PCSource     out  00 ALU result, 01 ALUOut, 10 jump target
//   retired      out  retired-instruction count (wraps)
//   state_dbg    out  current state encoding
//   illegal_op   out  sticky illegal-opcode flag
// ============================================================================
module mc_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_dbg,
    output logic                illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    state_t state_q, state_d;

    // Registered Moore outputs, loaded from the decode of the next state so
    // they line up with state_q without any combinational path from state.
    logic               pcwrite_q,     pcwrite_d;
    logic               pcwritecond_q, pcwritecond_d;
    logic               iord_q,        iord_d;
    logic               memread_q,     memread_d;
    logic               memwrite_q,    memwrite_d;
    logic               memtoreg_q,    memtoreg_d;
    logic               regdst_q,      regdst_d;
    logic               regwrite_q,    regwrite_d;
    logic               alusrca_q,     alusrca_d;
    logic [1:0]         alusrcb_q,     alusrcb_d;
    logic [ALUOP_W-1:0] aluop_q,       aluop_d;
    logic [1:0]         pcsource_q,    pcsource_d;

    logic [CNT_W-1:0]   retired_q;
    logic               retire_now;
    logic               fetch_done;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_RTEX;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            // Only lw and sw reach MEMADR, so the store opcode alone picks
            // the direction.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode of the next state
    // ------------------------------------------------------------------------
    always_comb begin
        pcwrite_d     = 1'b0;
        pcwritecond_d = 1'b0;
        iord_d        = 1'b0;
        memread_d     = 1'b0;
        memwrite_d    = 1'b0;
        memtoreg_d    = 1'b0;
        regdst_d      = 1'b0;
        regwrite_d    = 1'b0;
        alusrca_d     = 1'b0;
        alusrcb_d     = 2'b00;
        aluop_d       = ALU_ADD;
        pcsource_d    = 2'b00;
        case (state_d)
            S_FETCH: begin
                memread_d = 1'b1;
                alusrcb_d = 2'b01;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (imm << 2).
                alusrcb_d = 2'b11;
            end
            S_MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            S_MEMRD: begin
                memread_d = 1'b1;
                iord_d    = 1'b1;
            end
            S_MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
            end
            S_MEMWR: begin
                memwrite_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_RTEX: begin
                alusrca_d = 1'b1;
                aluop_d   = ALU_FUNCT;
            end
            S_RTWB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
            end
            S_BEQ: begin
                alusrca_d     = 1'b1;
                aluop_d       = ALU_SUB;
                pcwritecond_d = 1'b1;
                pcsource_d    = 2'b01;
            end
            S_ADDIEX: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_d = 1'b1;
            end
            S_JUMP: begin
                pcwrite_d  = 1'b1;
                pcsource_d = 2'b10;
            end
            default: ;
        endcase
    end

    // An instruction retires on the edge that leaves its final state. A store
    // is final only once memory accepts it.
    always_comb begin
        retire_now = 1'b0;
        case (state_q)
            S_MEMWB, S_RTWB, S_BEQ, S_ADDIWB, S_JUMP: retire_now = 1'b1;
            S_MEMWR:                                  retire_now = mem_ready;
            default:                                  retire_now = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, output and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pcwrite_q     <= 1'b0;
            pcwritecond_q <= 1'b0;
            iord_q        <= 1'b0;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            regdst_q      <= 1'b0;
            regwrite_q    <= 1'b0;
            alusrca_q     <= 1'b0;
            alusrcb_q     <= 2'b00;
            aluop_q       <= ALU_ADD;
            pcsource_q    <= 2'b00;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pcwrite_q     <= pcwrite_d;
            pcwritecond_q <= pcwritecond_d;
            iord_q        <= iord_d;
            memread_q     <= memread_d;
            memwrite_q    <= memwrite_d;
            memtoreg_q    <= memtoreg_d;
            regdst_q      <= regdst_d;
            regwrite_q    <= regwrite_d;
            alusrca_q     <= alusrca_d;
            alusrcb_q     <= alusrcb_d;
            aluop_q       <= aluop_d;
            pcsource_q    <= pcsource_d;
            if (retire_now) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Raised together with the entry into HALT so the flag and state_dbg=13
    // become visible in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_HALT) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs. IRWrite and the fetch half of PCWrite are the only Mealy
    // terms: the fetch completes in the very cycle memory reports ready.
    // ------------------------------------------------------------------------
    assign fetch_done  = (state_q == S_FETCH) && mem_ready;

    assign PCWrite     = pcwrite_q | fetch_done;
    assign IRWrite     = fetch_done;
    assign PCWriteCond = pcwritecond_q;
    assign IorD        = iord_q;
    assign MemRead     = memread_q;
    assign MemWrite    = memwrite_q;
    assign MemtoReg    = memtoreg_q;
    assign RegDst      = regdst_q;
    assign RegWrite    = regwrite_q;
    assign ALUSrcA     = alusrca_q;
    assign ALUSrcB     = alusrcb_q;
    assign ALUOp       = aluop_q;
    assign PCSource    = pcsource_q;
    assign retired     = retired_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control. Two instances share the stimulus: the default one
// (CNT_W=32) and a narrow one (CNT_W=4) whose counter wraps. Every cycle the
// driver pushes the expected output word for that cycle; the monitor pops and
// compares on the falling edge.
module tb_mc_control;

  localparam int W = 57;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWR = 4'd6, S_RTEX = 4'd7, S_RTWB = 4'd8,
                         S_BEQ = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JUMP = 4'd12, S_HALT = 4'd13;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000,
                         OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BAD = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] retired;
  logic [3:0]  state_dbg;
  logic        illegal_op;

  logic        n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite;
  logic        n_MemtoReg, n_RegDst, n_RegWrite, n_ALUSrcA;
  logic [1:0]  n_ALUSrcB, n_ALUOp, n_PCSource;
  logic [3:0]  n_retired;
  logic [3:0]  n_state_dbg;
  logic        n_illegal_op;

  mc_control u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .retired(retired), .state_dbg(state_dbg),
    .illegal_op(illegal_op)
  );

  mc_control #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD),
    .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
    .MemtoReg(n_MemtoReg), .RegDst(n_RegDst), .RegWrite(n_RegWrite),
    .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp),
    .PCSource(n_PCSource), .retired(n_retired), .state_dbg(n_state_dbg),
    .illegal_op(n_illegal_op)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_ret;
  logic         exp_ill;
  int           checks;
  int           errors;

  // Expected output word for one cycle in state st with mem_ready=mr.
  function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb, aop, psrc;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
    m2r = 0; rdst = 0; rw = 0; sa = 0; sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin sb = 2'b11; end
      S_MEMADR: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_RTEX:   begin sa = 1; aop = 2'b10; end
      S_RTWB:   begin rw = 1; rdst = 1; end
      S_BEQ:    begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      S_ADDIEX: begin sa = 1; sb = 2'b10; end
      S_ADDIWB: begin rw = 1; end
      S_JUMP:   begin pcw = 1; psrc = 2'b10; end
      default:  ;
    endcase
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop,
            psrc, exp_ill, exp_ret, exp_ret[3:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one cycle whose visible state is expected to be st, then advance.
  task automatic step(input logic [3:0] st, input logic [5:0] opc, input logic mr);
    opcode    = opc;
    mem_ready = mr;
    if (st == S_HALT) exp_ill = 1'b1;
    exp_q.push_back(exp_vec(st, mr));
    if (st == S_MEMWB || st == S_RTWB || st == S_BEQ || st == S_ADDIWB ||
        st == S_JUMP || (st == S_MEMWR && mr)) begin
      exp_ret = exp_ret + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n   = 1'b0;
    exp_ret = '0;
    exp_ill = 1'b0;
    repeat (2) step(S_IDLE, OP_R, 1'b1);
    rst_n = 1'b1;
    step(S_IDLE, OP_R, 1'b1);
  endtask

  // One instruction with fw fetch wait cycles and mw memory wait cycles.
  task automatic instr(input logic [5:0] opc, input int fw, input int mw);
    repeat (fw) step(S_FETCH, opc, 1'b0);
    step(S_FETCH, opc, 1'b1);
    step(S_DECODE, opc, 1'b0);
    case (opc)
      OP_LW: begin
        step(S_MEMADR, opc, 1'b0);
        repeat (mw) step(S_MEMRD, opc, 1'b0);
        step(S_MEMRD, opc, 1'b1);
        step(S_MEMWB, opc, 1'b0);
      end
      OP_SW: begin
        step(S_MEMADR, opc, 1'b0);
        repeat (mw) step(S_MEMWR, opc, 1'b0);
        step(S_MEMWR, opc, 1'b1);
      end
      OP_R: begin
        step(S_RTEX, opc, 1'b0);
        step(S_RTWB, opc, 1'b0);
      end
      OP_BEQ:  step(S_BEQ, opc, 1'b0);
      OP_ADDI: begin
        step(S_ADDIEX, opc, 1'b0);
        step(S_ADDIWB, opc, 1'b0);
      end
      OP_J:    step(S_JUMP, opc, 1'b0);
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {state_dbg, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             illegal_op, retired, n_retired};
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL ctrl exp_state=%0d got=%h exp=%h", e[W-1 -: 4], act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    exp_ret   = '0;
    exp_ill   = 1'b0;
    rst_n     = 1'b0;
    opcode    = OP_R;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset release: one IDLE cycle, then FETCH.
    do_reset();

    // lw without waits: 1,2,3,4,5.
    instr(OP_LW, 0, 0);

    // Fetch held for three cycles on an R-type.
    instr(OP_R, 3, 0);

    // Mix without waits.
    instr(OP_R, 0, 0);
    instr(OP_ADDI, 0, 0);
    instr(OP_BEQ, 0, 0);
    instr(OP_J, 0, 0);
    instr(OP_SW, 0, 0);

    // Memory-side waits.
    instr(OP_LW, 1, 2);
    instr(OP_SW, 0, 2);

    // Store aborted by reset while waiting on memory.
    step(S_FETCH, OP_SW, 1'b1);
    step(S_DECODE, OP_SW, 1'b0);
    step(S_MEMADR, OP_SW, 1'b0);
    step(S_MEMWR, OP_SW, 1'b0);
    step(S_MEMWR, OP_SW, 1'b0);
    do_reset();

    // 17 R-types: narrow counter wraps 15 -> 0 and ends at 1.
    for (int i = 0; i < 17; i++) instr(OP_R, 0, 0);

    // Unrecognised opcode.
    step(S_FETCH, OP_BAD, 1'b1);
    step(S_DECODE, OP_BAD, 1'b0);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    repeat (4) step(S_HALT, OP_BAD, 1'b1);
    do_reset();
    instr(OP_ADDI, 0, 0);
`else
    instr(OP_R, 0, 0);
`endif

    // Drain and confirm every expectation was consumed.
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got=%0d entries left exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
